signal_buffer_reader: RTL and testbench
=======================================

# signal_buffer_reader

Reads captured samples back out of the 256-entry signal buffer and streams them, in write order, to the filter datapath over a valid/ready handshake. Sits between the capture buffer and the filter core. Playback starts on a command pulse, runs for a sample count latched at start, and can be paced to a fixed sample interval. A done pulse marks the end of each run.

## Interface
- SAMPLE_W, 8, sample width in bits
- DEPTH, 256, buffer entries (power of two)
- IDX_W, $clog2(DEPTH), read index width
- PACE_DIV, 1, minimum clocks between successive sample offers (1 = back-to-back)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- inputSig  in  SAMPLE_W x DEPTH  buffer contents, indexed 0..DEPTH-1
- sampleCount  in  IDX_W+1  number of valid samples to play (0..DEPTH)
- startFlg  in  1  playback request pulse
- sampleReady  in  1  downstream accepts outputSample this cycle
- outputSample  out  SAMPLE_W  current sample
- sampleValid  out  1  outputSample is valid
- readIndex  out  IDX_W  index of the sample currently offered
- busyFlg  out  1  playback in progress
- doneFlg  out  1  one-cycle pulse after the last sample transfers

## Operation
- States: IDLE, OFFER, PACE, DONE.
- IDLE:
  - on startFlg with latched count N > 0: go to OFFER, with readIndex = 0 and outputSample = inputSig[0].
  - on startFlg with N = 0: go to DONE with no sample offered.
  - sampleCount values above DEPTH clamp to DEPTH when latched.
- OFFER:
  - sampleValid = 1.
  - A transfer occurs when sampleValid && sampleReady.
  - While sampleReady is low, outputSample and readIndex hold stable.
  - On a transfer of index k:
    - if k+1 = N, go to DONE;
    - else if PACE_DIV = 1, stay in OFFER with index k+1;
    - else go to PACE.
- PACE:
  - sampleValid = 0; the pace counter counts PACE_DIV-1 cycles.
  - When the count expires, return to OFFER with the next index.
- DONE: doneFlg = 1 for exactly one cycle, then IDLE.
- busyFlg = 1 in OFFER, PACE and DONE.
- startFlg is ignored in every state except IDLE. No restart and no queuing.
- The N latched at start is immune to later sampleCount changes.
- outputSample is registered from inputSig[readIndex] when an index is loaded. inputSig changes to an already-loaded entry do not affect the held sample.
- The index never wraps. With N = DEPTH, the last index is DEPTH-1, followed by DONE.

## Timing
- Reset values (rst low at a clock edge): state IDLE, outputSample 0, sampleValid 0, readIndex 0, busyFlg 0, doneFlg 0, pace counter 0.
- Reset mid-run aborts immediately: no doneFlg, and the next cycle is IDLE.
- Start latency: startFlg high at edge t gives sampleValid = 1 from cycle t+1.
- Back-to-back (PACE_DIV = 1), sampleReady held high: one sample per clock. N samples span cycles t+1..t+N, doneFlg is at t+N+1, and busyFlg falls at t+N+2.
- PACE_DIV = D > 1: successive valid cycles are at least D clocks apart under constant ready.
- Empty run (N = 0): doneFlg at t+1, sampleValid stays 0.
- startFlg high in the cycle DONE returns to IDLE: not accepted. The first accepted start is in the cycle busyFlg is low.

## Structure
- Shared package filter_pkg:
  - SAMPLE_W and DEPTH constants;
  - reader_state_t enum {IDLE, OFFER, PACE, DONE};
  - sample_t typedef.
- The writer side uses the same constants.
- One sub-module: pace_counter (load, count-down, expired flag, width $clog2(PACE_DIV)+1). It is instantiated only when PACE_DIV > 1.

## Test plan
- Reset: drive rst low for 2 cycles with startFlg high → all outputs 0, and no sampleValid after release until a new startFlg.
- Full run: inputSig[i] = i, N = 4, sampleReady tied high, PACE_DIV = 1 → samples 0,1,2,3 on consecutive cycles t+1..t+4, doneFlg at t+5.
- Backpressure: N = 3, sampleReady low for 3 cycles while index 1 is offered → outputSample = 1 and readIndex = 1 held stable, with no drop or duplicate.
- Empty and clamp: N = 0 → doneFlg at t+1, no valid. N = 300 → exactly 256 transfers, last readIndex 255, then doneFlg.
- Pacing: PACE_DIV = 4, N = 3, ready high → valid cycles at t+1, t+5, t+9, doneFlg at t+10.
- Interference: startFlg and a change of sampleCount mid-run → run length unchanged. rst low mid-run → no doneFlg, IDLE the next cycle.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants and types for the signal buffer writer/reader pair.
// Both sides size their buffers from SAMPLE_W and DEPTH.
package filter_pkg;

    localparam int SAMPLE_W = 8;
    localparam int DEPTH    = 256;
    localparam int IDX_W    = $clog2(DEPTH);

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        PACE,
        DONE
    } reader_state_t;

endpackage

// File: rtl/signal_buffer_reader_pace_counter.sv
// Down-counter that spaces successive sample offers.
// Loaded on each transfer, expires on its final counted cycle.
module pace_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/signal_buffer_reader.sv
// Streams captured samples from the signal buffer to the filter core.
// Runs a latched sample count, optionally paced, ending in a done pulse.
module signal_buffer_reader
    import filter_pkg::*;
#(
    parameter int SAMPLE_W = filter_pkg::SAMPLE_W,
    parameter int DEPTH    = filter_pkg::DEPTH,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int PACE_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_W*DEPTH-1:0] inputSig,
    input  logic [IDX_W:0]            sampleCount,
    input  logic                      startFlg,
    input  logic                      sampleReady,
    output logic [SAMPLE_W-1:0]       outputSample,
    output logic                      sampleValid,
    output logic [IDX_W-1:0]          readIndex,
    output logic                      busyFlg,
    output logic                      doneFlg
);

    localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);

    reader_state_t        state_q;
    reader_state_t        state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [SAMPLE_W-1:0]  smp_q;
    logic [SAMPLE_W-1:0]  smp_d;
    logic [IDX_W:0]       cnt_q;
    logic [IDX_W:0]       cnt_d;

    logic [SAMPLE_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W:0]       xfer_num;
    logic [IDX_W:0]       cnt_clamp;
    logic                 pace_load;
    logic                 pace_en;
    logic                 pace_exp;

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        assign mem[i] = inputSig[i*SAMPLE_W +: SAMPLE_W];
    end

    assign idx_nxt   = idx_q + IDX_W'(1);
    assign xfer_num  = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign cnt_clamp = (sampleCount > DEPTH_N) ? DEPTH_N : sampleCount;

    // Pace counter only exists when offers must be spaced out.
    if (PACE_DIV > 1) begin : g_pace
        localparam int CW = $clog2(PACE_DIV) + 1;
        localparam logic [CW-1:0] PACE_LD = CW'(PACE_DIV - 1);

        pace_counter #(
            .W(CW)
        ) u_pace (
            .clk       (clk),
            .rst       (rst),
            .load_i    (pace_load),
            .load_val_i(PACE_LD),
            .en_i      (pace_en),
            .expired_o (pace_exp)
        );
    end else begin : g_nopace
        logic unused_pace;
        assign unused_pace = pace_load ^ pace_en;
        assign pace_exp    = 1'b1;
    end

    // Next-state, index and sample selection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        smp_d     = smp_q;
        cnt_d     = cnt_q;
        pace_load = 1'b0;
        pace_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startFlg) begin
                    cnt_d = cnt_clamp;
                    if (cnt_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = OFFER;
                        idx_d   = '0;
                        smp_d   = mem[0];
                    end
                end
            end
            OFFER: begin
                if (sampleReady) begin
                    if (xfer_num == cnt_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_nxt;
                        smp_d = mem[idx_nxt];
                        if (PACE_DIV > 1) begin
                            state_d   = PACE;
                            pace_load = 1'b1;
                        end
                    end
                end
            end
            PACE: begin
                pace_en = 1'b1;
                if (pace_exp) begin
                    state_d = OFFER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            smp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outputSample = smp_q;
    assign readIndex    = idx_q;
    assign sampleValid  = (state_q == OFFER);
    assign busyFlg      = (state_q != IDLE);
    assign doneFlg      = (state_q == DONE);

endmodule

// File: tb/tb_signal_buffer_reader.sv
// Directed bench for signal_buffer_reader.
// Checks back-to-back and paced instances against hand-derived timing.
module tb_signal_buffer_reader;

    localparam int SW = 8;
    localparam int DP = 256;
    localparam int IW = 8;

    logic              clk;
    logic              rst;
    logic [SW*DP-1:0]  isig;
    logic [IW:0]       scnt;
    logic              start1;
    logic              start4;
    logic              rdy;

    logic [SW-1:0]     smp1;
    logic              vld1;
    logic [IW-1:0]     idx1;
    logic              busy1;
    logic              done1;

    logic [SW-1:0]     smp4;
    logic              vld4;
    logic [IW-1:0]     idx4;
    logic              busy4;
    logic              done4;

    int total;
    int bad;

    signal_buffer_reader #(
        .SAMPLE_W(SW), .DEPTH(DP), .IDX_W(IW), .PACE_DIV(1)
    ) u_dut (
        .clk(clk), .rst(rst), .inputSig(isig), .sampleCount(scnt),
        .startFlg(start1), .sampleReady(rdy),
        .outputSample(smp1), .sampleValid(vld1), .readIndex(idx1),
        .busyFlg(busy1), .doneFlg(done1)
    );

    signal_buffer_reader #(
        .SAMPLE_W(SW), .DEPTH(DP), .IDX_W(IW), .PACE_DIV(4)
    ) u_pace (
        .clk(clk), .rst(rst), .inputSig(isig), .sampleCount(scnt),
        .startFlg(start4), .sampleReady(rdy),
        .outputSample(smp4), .sampleValid(vld4), .readIndex(idx4),
        .busyFlg(busy4), .doneFlg(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int last;
        int cyc;
        logic exp_v;
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        start1 = 1'b1;
        start4 = 1'b1;
        rdy    = 1'b1;
        scnt   = 9'd4;
        for (int i = 0; i < DP; i++) isig[i*SW +: SW] = SW'(i);

        // reset with start held high
        tick();
        tick();
        chk("rst_valid", 32'(vld1), 0);
        chk("rst_sample", 32'(smp1), 0);
        chk("rst_index", 32'(idx1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_busy4", 32'(busy4), 0);
        start1 = 1'b0;
        start4 = 1'b0;
        rst    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_valid", 32'(vld1), 0);
        end

        // full run N=4 back-to-back
        scnt   = 9'd4;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("full_valid", 32'(vld1), 1);
            chk("full_sample", 32'(smp1), 32'(k));
            chk("full_index", 32'(idx1), 32'(k));
            tick();
        end
        chk("full_done", 32'(done1), 1);
        chk("full_done_novalid", 32'(vld1), 0);
        tick();
        chk("full_done_pulse", 32'(done1), 0);
        chk("full_busy_fall", 32'(busy1), 0);

        // backpressure N=3
        scnt   = 9'd3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("bp_idx0", 32'(idx1), 0);
        tick();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(vld1), 1);
            chk("bp_hold_sample", 32'(smp1), 1);
            chk("bp_hold_index", 32'(idx1), 1);
            tick();
        end
        rdy = 1'b1;
        chk("bp_release_index", 32'(idx1), 1);
        tick();
        chk("bp_next_sample", 32'(smp1), 2);
        chk("bp_next_index", 32'(idx1), 2);
        tick();
        chk("bp_done", 32'(done1), 1);
        tick();

        // empty run
        scnt   = 9'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("empty_done", 32'(done1), 1);
        chk("empty_valid", 32'(vld1), 0);
        tick();
        chk("empty_idle", 32'(busy1), 0);
        chk("empty_valid2", 32'(vld1), 0);

        // clamp: 300 requested, 256 played
        scnt   = 9'd300;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n    = 0;
        last = -1;
        cyc  = 0;
        while (!done1 && cyc < 400) begin
            if (vld1) begin
                n++;
                last = int'(idx1);
            end
            tick();
            cyc++;
        end
        chk("clamp_done_seen", 32'(done1), 1);
        chk("clamp_count", 32'(n), 256);
        chk("clamp_last_index", 32'(last), 255);
        tick();

        // start and count change mid-run; start during DONE ignored
        scnt   = 9'd5;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        start1 = 1'b1;
        scnt   = 9'd2;
        tick();
        start1 = 1'b0;
        n   = 2;
        cyc = 0;
        while (!done1 && cyc < 50) begin
            if (vld1) n++;
            tick();
            cyc++;
        end
        chk("intf_done_seen", 32'(done1), 1);
        chk("intf_len", 32'(n), 5);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("intf_done_start_busy", 32'(busy1), 0);
        chk("intf_done_start_valid", 32'(vld1), 0);

        // reset mid-run
        scnt   = 9'd10;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy1), 0);
        chk("midrst_valid", 32'(vld1), 0);
        chk("midrst_done", 32'(done1), 0);
        chk("midrst_index", 32'(idx1), 0);
        rst = 1'b1;
        tick();
        chk("midrst_done2", 32'(done1), 0);
        chk("midrst_valid2", 32'(vld1), 0);

        // paced run, PACE_DIV=4, N=3
        scnt   = 9'd3;
        rdy    = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            exp_v = (c == 1) || (c == 5) || (c == 9);
            chk("pace_valid", 32'(vld4), 32'(exp_v));
            chk("pace_done", 32'(done4), 32'(c == 10));
            if (c == 5) chk("pace_sample1", 32'(smp4), 1);
            if (c == 9) chk("pace_sample2", 32'(smp4), 2);
            tick();
        end
        chk("pace_idle", 32'(busy4), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
